fsm_table_engine: RTL

Runtime-programmable, table-driven state machine engine. Each (state, input) pair holds an entry with enable, priority and next-state fields. Every enabled cycle the engine picks the highest-priority asserted input of the current state's row and moves to that entry's next state. It sits beside control logic that needs sequencing reprogrammed by software without resynthesis. It extends the package-level next-state function with parametrised sizes, a registered state, a config write port, soft restart and dwell counting.

---
 rtl/fsm_pkg.sv | 37 +++
 rtl/fsm_prio_sel.sv | 30 +++
 rtl/fsm_table_engine.sv | 102 ++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// fsm_pkg: default sizes, table entry type and priority-resolve helper for the table-driven FSM engine
package fsm_pkg;

    localparam int DEF_N_STATES = 16;
    localparam int DEF_N_INPUTS = 16;
    localparam int DEF_PRIO_W   = 4;
    localparam int DEF_DWELL_W  = 16;
    localparam int DEF_SW       = $clog2(DEF_N_STATES);
    localparam int DEF_IW       = $clog2(DEF_N_INPUTS);

    typedef struct packed {
        logic                  en;
        logic [DEF_PRIO_W-1:0] prio;
        logic [DEF_SW-1:0]     next;
    } entry_t;

    typedef struct packed {
        logic              valid;
        logic [DEF_IW-1:0] idx;
    } pick_t;

    // Highest nonzero effective priority wins; strict compare keeps the lowest index on ties.
    function automatic pick_t prio_resolve(input entry_t [DEF_N_INPUTS-1:0] row,
                                           input logic [DEF_N_INPUTS-1:0] sig);
        logic [DEF_PRIO_W-1:0] best;
        best = '0;
        prio_resolve = '0;
        for (int i = 0; i < DEF_N_INPUTS; i++) begin
            if (row[i].en && sig[i] && row[i].prio > best) begin
                best = row[i].prio;
                prio_resolve.valid = 1'b1;
                prio_resolve.idx = DEF_IW'(i);
            end
        end
    endfunction

endpackage

// File: rtl/fsm_prio_sel.sv
// fsm_prio_sel: combinational winner pick over one table row
module fsm_prio_sel import fsm_pkg::*; #(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int PRIO_W   = DEF_PRIO_W,
    parameter int IW       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic [N_INPUTS-1:0]             en,
    input  logic [N_INPUTS-1:0][PRIO_W-1:0] prio,
    input  logic [N_INPUTS-1:0]             sig,
    output logic [IW-1:0]                   idx,
    output logic                            found
);

    logic [PRIO_W-1:0] best;

    // Scan columns; only a strictly larger priority displaces the current pick, so ties keep the lowest index.
    always_comb begin
        best  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (en[i] && sig[i] && prio[i] > best) begin
                best  = prio[i];
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_table_engine.sv
// fsm_table_engine: runtime-programmable table-driven state machine with dwell counter
module fsm_table_engine import fsm_pkg::*; #(
    parameter int N_STATES   = DEF_N_STATES,
    parameter int N_INPUTS   = DEF_N_INPUTS,
    parameter int PRIO_W     = DEF_PRIO_W,
    parameter int DWELL_W    = DEF_DWELL_W,
    parameter int INIT_STATE = 0,
    localparam int SW = $clog2(N_STATES),
    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                restart,
    input  logic [N_INPUTS-1:0] sig,
    input  logic                cfg_we,
    input  logic [SW-1:0]       cfg_state,
    input  logic [IW-1:0]       cfg_input,
    input  logic                cfg_en,
    input  logic [PRIO_W-1:0]   cfg_prio,
    input  logic [SW-1:0]       cfg_next,
    output logic                cfg_err,
    output logic [SW-1:0]       state,
    output logic                trans,
    output logic [IW-1:0]       trans_input,
    output logic [DWELL_W-1:0]  dwell
);

    typedef struct packed {
        logic              en;
        logic [PRIO_W-1:0] prio;
        logic [SW-1:0]     next;
    } row_entry_t;

    row_entry_t                      tbl [N_STATES][N_INPUTS];
    logic [N_INPUTS-1:0]             row_en;
    logic [N_INPUTS-1:0][PRIO_W-1:0] row_prio;
    logic [IW-1:0]                   win;
    logic                            found;
    logic                            bad;

    // Read the whole current row in parallel and flag out-of-range config writes.
    always_comb begin
        row_en   = '0;
        row_prio = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            row_en[i]   = tbl[state][i].en;
            row_prio[i] = tbl[state][i].prio;
        end
        bad = (32'(cfg_state) >= N_STATES) || (32'(cfg_input) >= N_INPUTS) || (32'(cfg_next) >= N_STATES);
    end

    fsm_prio_sel #(
        .N_INPUTS (N_INPUTS),
        .PRIO_W   (PRIO_W),
        .IW       (IW)
    ) u_sel (
        .en    (row_en),
        .prio  (row_prio),
        .sig   (sig),
        .idx   (win),
        .found (found)
    );

    // Table flops: cleared on reset, one validated entry written per cycle (visible from the next cycle).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < N_STATES; s++)
                for (int i = 0; i < N_INPUTS; i++)
                    tbl[s][i] <= '0;
        end else if (cfg_we && !bad) begin
            tbl[cfg_state][cfg_input] <= '{en: cfg_en, prio: cfg_prio, next: cfg_next};
        end
    end

    // State register: restart beats evaluation; otherwise take the winner or hold and count dwell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SW'(INIT_STATE);
            trans       <= 1'b0;
            trans_input <= '0;
            dwell       <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_we && bad;
            if (restart) begin
                state <= SW'(INIT_STATE);
                trans <= 1'b0;
                dwell <= '0;
            end else if (run && found) begin
                state       <= tbl[state][win].next;
                trans       <= 1'b1;
                trans_input <= win;
                dwell       <= '0;
            end else begin
                trans <= 1'b0;
                dwell <= (&dwell) ? dwell : dwell + 1'b1;
            end
        end
    end

endmodule
